// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - shared constants for the RV32I write-back stage
package rv_wb_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - extracts, sign/zero-extends load data and flags misalignment
module load_align
    import rv_wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unknown funct3 values fall back to a full-word read that is never misaligned.
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB: data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {16'd0, half_sel};
                misaligned = off[0];
            end
            F3_LW: misaligned = (off != 2'd0);
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB latch, load alignment, register-bank write port and retire counter
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_in,
    input  logic             stall_in,
    input  logic [1:0]       crt_wb_in,
    input  logic [2:0]       funct3_in,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [XLEN-1:0]  mem_rdata_in,
    input  logic [4:0]       rd_in,
    output logic [XLEN-1:0]  write_data,
    output logic [4:0]       write_reg,
    output logic             reg_write,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired_count
);
    import rv_wb_pkg::*;

    logic             valid_q, valid_d;
    logic [1:0]       crt_q, crt_d;
    logic [2:0]       f3_q, f3_d;
    logic [XLEN-1:0]  alu_q, alu_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [4:0]       rd_q, rd_d;
    logic             misalign_err_q, misalign_err_d;
    logic [CNT_W-1:0] retired_count_q, retired_count_d;

    logic [XLEN-1:0]  load_data;
    logic             load_mis;
    logic             mis;
    logic             retire;

    load_align u_load_align (
        .funct3     (f3_q),
        .off        (alu_q[1:0]),
        .rdata      (rdata_q),
        .data       (load_data),
        .misaligned (load_mis)
    );

    always_comb begin
        valid_d = valid_q;
        crt_d   = crt_q;
        f3_d    = f3_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        if (!stall_in) begin
            valid_d = mem_valid_in;
            crt_d   = crt_wb_in;
            f3_d    = funct3_in;
            alu_d   = alu_result_in;
            rdata_d = mem_rdata_in;
            rd_d    = rd_in;
        end
    end

    // An instruction retires once, on the edge that lets it leave the latch.
    always_comb begin
        mis             = crt_q[WB_MEMTOREG] & load_mis;
        retire          = valid_q & ~stall_in;
        retired_count_d = retired_count_q + CNT_W'(retire);
        misalign_err_d  = misalign_err_q | (retire & mis);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q         <= 1'b0;
            crt_q           <= '0;
            f3_q            <= '0;
            alu_q           <= '0;
            rdata_q         <= '0;
            rd_q            <= '0;
            misalign_err_q  <= 1'b0;
            retired_count_q <= '0;
        end else begin
            valid_q         <= valid_d;
            crt_q           <= crt_d;
            f3_q            <= f3_d;
            alu_q           <= alu_d;
            rdata_q         <= rdata_d;
            rd_q            <= rd_d;
            misalign_err_q  <= misalign_err_d;
            retired_count_q <= retired_count_d;
        end
    end

    always_comb begin
        write_data    = crt_q[WB_MEMTOREG] ? load_data : alu_q;
        write_reg     = rd_q;
        reg_write     = valid_q & crt_q[WB_REGWRITE] & (rd_q != 5'd0) & ~mis;
        misalign_err  = misalign_err_q;
        retired_count = retired_count_q;
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic        stall_in = 1'b0;
    logic [1:0]  crt_wb_in = '0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] mem_rdata_in = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        misalign_err;
    logic [31:0] retired_count;

    wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid_in  (mem_valid_in),
        .stall_in      (stall_in),
        .crt_wb_in     (crt_wb_in),
        .funct3_in     (funct3_in),
        .alu_result_in (alu_result_in),
        .mem_rdata_in  (mem_rdata_in),
        .rd_in         (rd_in),
        .write_data    (write_data),
        .write_reg     (write_reg),
        .reg_write     (reg_write),
        .misalign_err  (misalign_err),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic        m_valid = 1'b0;
    logic [1:0]  m_crt = '0;
    logic [2:0]  m_f3 = '0;
    logic [31:0] m_alu = '0;
    logic [31:0] m_rdata = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] exp_cnt = '0;
    logic        exp_mis = 1'b0;

    typedef struct {
        string       name;
        logic [1:0]  crt;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rw;
    } vec_t;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] alu,
                                             input logic [31:0] rdata);
        int off = int'(alu % 4);
        int b   = int'((rdata >> (8 * off)) % 256);
        int h   = int'((rdata >> (16 * (off / 2))) % 65536);
        case (f3)
            3'd0:    return 32'(b >= 128 ? b - 256 : b);
            3'd4:    return 32'(b);
            3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd5:    return 32'(h);
            default: return rdata;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] alu);
        int off = int'(alu % 4);
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 1;
        if (f3 == 3'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_wd();
        return m_crt[1] ? ref_load(m_f3, m_alu, m_rdata) : m_alu;
    endfunction

    function automatic logic exp_rw();
        return m_valid && m_crt[0] && (m_rd != 0) && !(m_crt[1] && ref_mis(m_f3, m_alu));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    // Model advances from the inputs presented before the edge, then the edge happens.
    task automatic tick();
        if (!rst) begin
            m_valid = 0; m_crt = 0; m_f3 = 0; m_alu = 0; m_rdata = 0; m_rd = 0;
            exp_cnt = 0; exp_mis = 0;
        end else begin
            if (m_valid && !stall_in) begin
                exp_cnt = exp_cnt + 1;
                if (m_crt[1] && ref_mis(m_f3, m_alu)) exp_mis = 1;
            end
            if (!stall_in) begin
                m_valid = mem_valid_in; m_crt = crt_wb_in; m_f3 = funct3_in;
                m_alu = alu_result_in; m_rdata = mem_rdata_in; m_rd = rd_in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] crt, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd);
        mem_valid_in = v; crt_wb_in = crt; funct3_in = f3;
        alu_result_in = alu; mem_rdata_in = rdata; rd_in = rd;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".write_data"}, write_data, exp_wd());
        check({tag, ".write_reg"}, 32'(write_reg), 32'(m_rd));
        check({tag, ".reg_write"}, 32'(reg_write), 32'(exp_rw()));
        check({tag, ".misalign_err"}, 32'(misalign_err), 32'(exp_mis));
        check({tag, ".retired_count"}, retired_count, exp_cnt);
    endtask

    vec_t vecs[$];
    logic [31:0] cnt_before;

    initial begin
        vecs.push_back('{"lb_off3",   2'b11, 3'b000, 32'h0000_1003, 5'd1, 32'hFFFF_FF80, 1'b1});
        vecs.push_back('{"lbu_off1",  2'b11, 3'b100, 32'h0000_2001, 5'd2, 32'h0000_007F, 1'b1});
        vecs.push_back('{"lh_off2",   2'b11, 3'b001, 32'h0000_3002, 5'd3, 32'hFFFF_80FF, 1'b1});
        vecs.push_back('{"lhu_off0",  2'b11, 3'b101, 32'h0000_4000, 5'd4, 32'h0000_7F01, 1'b1});
        vecs.push_back('{"lw_off0",   2'b11, 3'b010, 32'h0000_5000, 5'd6, 32'h80FF_7F01, 1'b1});
        vecs.push_back('{"f3_011",    2'b11, 3'b011, 32'h0000_6003, 5'd8, 32'h80FF_7F01, 1'b1});
        vecs.push_back('{"x0_write",  2'b01, 3'b000, 32'h0000_BEEF, 5'd0, 32'h0000_BEEF, 1'b0});
        vecs.push_back('{"memtoreg_only", 2'b10, 3'b000, 32'h0000_0002, 5'd9, 32'hFFFF_FFFF, 1'b0});

        // Reset with random inputs
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
            stall_in = 1'($urandom);
            tick();
        end
        check("rst.reg_write", 32'(reg_write), 32'd0);
        check("rst.write_data", write_data, 32'd0);
        check("rst.write_reg", 32'(write_reg), 32'd0);
        check("rst.retired_count", retired_count, 32'd0);
        check("rst.misalign_err", 32'(misalign_err), 32'd0);

        rst = 1; stall_in = 0;
        drive(1'b1, 2'b01, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        check("alu.reg_write", 32'(reg_write), 32'd1);
        check("alu.write_reg", 32'(write_reg), 32'd5);
        check("alu.write_data", write_data, 32'h0000_1234);
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        tick();
        check("alu.retired_count", retired_count, 32'd1);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].crt, vecs[i].f3, vecs[i].alu, 32'h80FF_7F01, vecs[i].rd);
            tick();
            check({vecs[i].name, ".write_data"}, write_data, vecs[i].wd);
            check({vecs[i].name, ".reg_write"}, 32'(reg_write), 32'(vecs[i].rw));
            check({vecs[i].name, ".write_reg"}, 32'(write_reg), 32'(vecs[i].rd));
            check({vecs[i].name, ".retired_count"}, retired_count, 32'd1 + 32'(i));
        end

        // Misaligned LW: write suppressed, flag sticky
        drive(1'b1, 2'b11, 3'b010, 32'h0000_0102, 32'h1111_2222, 5'd3);
        tick();
        check("mis.reg_write", 32'(reg_write), 32'd0);
        check("mis.flag_before_retire", 32'(misalign_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b01, 3'b000, 32'(i), 32'h0, 5'(i + 1));
            tick();
            check("mis.sticky", 32'(misalign_err), 32'd1);
        end
        check("mis.after.reg_write", 32'(reg_write), 32'd1);
        check("mis.after.retired_count", retired_count, exp_cnt);

        // Stall holds the latch; retire counted once after release
        drive(1'b1, 2'b01, 3'b000, 32'hCAFE_0007, 32'h0, 5'd7);
        tick();
        cnt_before = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            stall_in = 1;
            drive(1'b1, 2'($urandom), 3'($urandom), $urandom, $urandom, 5'd9);
            tick();
            check("stall.write_reg", 32'(write_reg), 32'd7);
            check("stall.write_data", write_data, 32'hCAFE_0007);
            check("stall.reg_write", 32'(reg_write), 32'd1);
            check("stall.retired_count", retired_count, cnt_before);
        end
        stall_in = 0;
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        tick();
        check("stall.release_count", retired_count, cnt_before + 32'd1);

        // Counter wrap from a forced all-ones value
        drive(1'b1, 2'b01, 3'b000, 32'h5, 32'h0, 5'd2);
        tick();
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        exp_cnt = 32'hFFFF_FFFF;
        check("wrap.preload", retired_count, 32'hFFFF_FFFF);
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        tick();
        check("wrap.zero", retired_count, 32'd0);

        // Reset with a valid instruction latched
        drive(1'b1, 2'b01, 3'b000, 32'h77, 32'h0, 5'd4);
        tick();
        check("midrst.before", 32'(reg_write), 32'd1);
        rst = 0;
        tick();
        check("midrst.reg_write", 32'(reg_write), 32'd0);
        check("midrst.retired_count", retired_count, 32'd0);
        rst = 1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom % 60) != 0;
            stall_in = ($urandom % 4) == 0;
            drive(($urandom % 4) != 0, 2'($urandom), 3'($urandom), $urandom, $urandom,
                  5'($urandom % 8));
            tick();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RV32I pipeline. Holds the MEM/WB pipeline register.
- Extracts, aligns and sign-extends load data, selects between ALU result and load data, and drives the register-bank write port of the decode stage (WRITE_DATA, INST, CRT_WB_IN).
- Also maintains a retired-instruction counter and a sticky misaligned-load flag.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- mem_valid_in  in  1  MEM stage presents a valid instruction
- stall_in  in  1  hazard unit holds the WB latch
- crt_wb_in  in  2  [0] RegWrite, [1] MemtoReg; same encoding as decode's CRT_WB_OUT
- funct3_in  in  3  instruction funct3; selects the load size
- alu_result_in  in  32  ALU result; also the load effective address
- mem_rdata_in  in  32  word-aligned data-memory read word
- rd_in  in  5  destination register index
- write_data  out  32  data to the register bank (WRITE_DATA)
- write_reg  out  5  destination index (INST)
- reg_write  out  1  write enable (CRT_WB_IN)
- misalign_err  out  1  sticky misaligned-load flag
- retired_count  out  CNT_W  count of instructions retired

Behaviour:
- Sampling: all state updates on the rising edge of clk.
- Reset: when rst=0 at an edge, the following are cleared to 0:
  - the latch: valid_q, crt_q, f3_q, alu_q, rdata_q, rd_q
  - misalign_err and retired_count
  - Outputs after reset: write_data=0, write_reg=0, reg_write=0.
- Reset mid-operation discards the latched instruction; no write occurs.
- Latch update, when rst=1:
  - stall_in=0: every latch field loads from its input, and valid_q <= mem_valid_in.
  - stall_in=1: the latch holds.
- Latency: exactly 1 cycle from input sample to outputs. Outputs are combinational from the latch only; there is no input-to-output combinational path.
- Offset: off = alu_q[1:0].
- Load extraction, applied when crt_q[1]=1:
  - 000 LB: byte at off, sign-extended.
  - 001 LH: half at off[1], sign-extended; misaligned if off[0]=1.
  - 010 LW: full word; misaligned if off!=0.
  - 100 LBU: byte at off, zero-extended.
  - 101 LHU: half at off[1], zero-extended; misaligned if off[0]=1.
  - Any other funct3: full word, never misaligned.
- write_data = extracted load data if crt_q[1]=1, else alu_q.
- write_reg = rd_q.
- reg_write = valid_q & crt_q[0] & (rd_q!=0) & !mis.
  - mis = crt_q[1] & misaligned.
  - Writes to x0 are always suppressed.
- misalign_err:
  - Set at the edge where valid_q & mis & !stall_in.
  - Stays set until reset.
  - A suppressed write still counts as retired.
- retired_count:
  - Increments by 1 at each edge where valid_q=1 and stall_in=0, i.e. once per instruction regardless of how long it is stalled.
  - Wraps from all-ones to 0.
- Stall with valid_q=1: reg_write stays asserted with identical data every cycle. This is benign: it is an idempotent rewrite to the bank.
- Simultaneous stall_in=1 and mem_valid_in=1: the incoming instruction is not captured. Upstream must hold it.

Decomposition:
- Package rv_wb_pkg holds:
  - load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - CRT_WB bit indices: WB_REGWRITE=0, WB_MEMTOREG=1
  - XLEN
- Sub-module load_align (combinational):
  - Inputs: funct3, off[1:0], rdata[31:0].
  - Outputs: data[31:0], misaligned.
  - Instantiated once.
- Top level holds the latch, counter, flag and output mux.

Test Plan:
- Reset: hold rst=0 two cycles with random inputs. Required: reg_write=0, write_data=0, retired_count=0, misalign_err=0.
- ALU writeback: valid, crt_wb=01, rd=5, alu=0x0000_1234. Required next cycle: reg_write=1, write_reg=5, write_data=0x0000_1234, retired_count=1.
- Loads with mem_rdata=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=1 -> 0x0000_007F.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW off=0 -> 0x80FF_7F01.
- x0 and misaligned:
  - rd=0, crt_wb=01 -> reg_write=0, count still increments.
  - LW alu=0x0000_0102 -> reg_write=0, misalign_err=1, and it stays 1 after 10 further valid ALU ops.
- Stall: latch an ALU op to rd=7, then stall_in=1 for 3 cycles while inputs change. Required: write_reg=7 and data unchanged for all 3 cycles, retired_count increments once, only after the stall releases.
- Wrap and mid-op reset:
  - Preload retired_count to 0xFFFF_FFFF via a forced counter value, retire one instruction -> 0.
  - Assert rst=0 with valid_q=1 -> reg_write=0 the next cycle.
